dw_conv_mac_pipe: RTL

//  Multi-channel depthwise MAC pipeline: CH lanes each take one K_DIM x K_DIM signed window and kernel,
//  add a per-lane bias and emit one accumulator per lane. Sits between the line-buffer window

---
 rtl/dw_conv_mac_pipe.sv | 173 +++++++++++++++++
 1 files changed

// File: rtl/dw_conv_mac_pipe.sv
// Multi-channel depthwise MAC pipeline: per-lane K_DIM x K_DIM dot product plus bias, valid/ready.
// Define DW_REQUANT_EN to add a rounding/saturating requant stage (latency 4 instead of 3).
module dw_conv_mac_pipe #(
    parameter int          DATA_W    = 8,
    parameter int          K_DIM     = 3,
    parameter int          CH        = 4,
    parameter int          ACC_W     = 32,
    parameter int unsigned OUT_SHIFT = 0
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            i_valid,
    output logic                            i_ready,
    input  logic [CH*K_DIM*K_DIM*DATA_W-1:0] i_win_flat,
    input  logic [CH*K_DIM*K_DIM*DATA_W-1:0] i_kernel_flat,
    input  logic [CH*ACC_W-1:0]             i_bias_flat,
    output logic                            o_valid,
    input  logic                            o_ready,
    output logic [CH*ACC_W-1:0]             o_acc_flat
);

    localparam int K_SZ = K_DIM * K_DIM;
    localparam int P_W  = 2 * DATA_W;

    if (ACC_W < 2 * DATA_W + $clog2(K_SZ) + 1) begin : g_chk_acc_w
        $error("ACC_W too narrow for DATA_W and K_DIM");
    end
    if (OUT_SHIFT >= ACC_W) begin : g_chk_shift
        $error("OUT_SHIFT must be below ACC_W");
    end

    logic w_en;
    logic r_out_valid;
    logic [CH*ACC_W-1:0] r_out_acc;

    // Whole pipe moves together; it only freezes when the output register is full and blocked.
    assign w_en       = !r_out_valid || o_ready;
    assign i_ready    = w_en;
    assign o_valid    = r_out_valid;
    assign o_acc_flat = r_out_acc;

    // S1: tap products and bias
    logic                    r_s1_valid;
    logic signed [P_W-1:0]   r_s1_prod [CH][K_SZ];
    logic signed [ACC_W-1:0] r_s1_bias [CH];
    logic signed [P_W-1:0]   w_prod    [CH][K_SZ];

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            for (int j = 0; j < K_SZ; j++) begin
                w_prod[c][j] = P_W'($signed(i_win_flat[(c*K_SZ+j)*DATA_W +: DATA_W]))
                             * P_W'($signed(i_kernel_flat[(c*K_SZ+j)*DATA_W +: DATA_W]));
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_prod  <= '{default: '0};
            r_s1_bias  <= '{default: '0};
        end else if (w_en) begin
            r_s1_valid <= i_valid;
            if (i_valid) begin
                r_s1_prod <= w_prod;
                for (int c = 0; c < CH; c++) begin
                    r_s1_bias[c] <= i_bias_flat[c*ACC_W +: ACC_W];
                end
            end
        end
    end

    // S2: row sums
    logic                    r_s2_valid;
    logic signed [ACC_W-1:0] r_s2_row  [CH][K_DIM];
    logic signed [ACC_W-1:0] r_s2_bias [CH];
    logic signed [ACC_W-1:0] w_row     [CH][K_DIM];

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            for (int k = 0; k < K_DIM; k++) begin
                w_row[c][k] = '0;
                for (int t = 0; t < K_DIM; t++) begin
                    w_row[c][k] = w_row[c][k] + ACC_W'(r_s1_prod[c][k*K_DIM+t]);
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_row   <= '{default: '0};
            r_s2_bias  <= '{default: '0};
        end else if (w_en) begin
            r_s2_valid <= r_s1_valid;
            r_s2_row   <= w_row;
            r_s2_bias  <= r_s1_bias;
        end
    end

    // S3 sum (wraps in ACC_W)
    logic signed [ACC_W-1:0] w_acc [CH];

    always_comb begin
        for (int c = 0; c < CH; c++) begin
            w_acc[c] = r_s2_bias[c];
            for (int k = 0; k < K_DIM; k++) begin
                w_acc[c] = w_acc[c] + r_s2_row[c][k];
            end
        end
    end

    logic                    w_fin_valid;
    logic signed [ACC_W-1:0] w_fin [CH];

`ifdef DW_REQUANT_EN
    localparam logic signed [ACC_W:0] RND =
        (OUT_SHIFT == 0) ? '0 : ((ACC_W+1)'(1) << (OUT_SHIFT - 1));
    localparam logic signed [ACC_W:0] SAT_MAX = (ACC_W+1)'((1 << (DATA_W - 1)) - 1);
    localparam logic signed [ACC_W:0] SAT_MIN = -SAT_MAX - 1;

    logic                    r_s3_valid;
    logic signed [ACC_W-1:0] r_s3_acc [CH];
    logic signed [ACC_W:0]   w_rnd    [CH];
    logic signed [ACC_W:0]   w_shr    [CH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s3_valid <= 1'b0;
            r_s3_acc   <= '{default: '0};
        end else if (w_en) begin
            r_s3_valid <= r_s2_valid;
            r_s3_acc   <= w_acc;
        end
    end

    // One guard bit so the rounding add cannot wrap before the shift.
    always_comb begin
        w_fin_valid = r_s3_valid;
        for (int c = 0; c < CH; c++) begin
            w_rnd[c] = {r_s3_acc[c][ACC_W-1], r_s3_acc[c]} + RND;
            w_shr[c] = w_rnd[c] >>> OUT_SHIFT;
            if (w_shr[c] > SAT_MAX) begin
                w_fin[c] = SAT_MAX[ACC_W-1:0];
            end else if (w_shr[c] < SAT_MIN) begin
                w_fin[c] = SAT_MIN[ACC_W-1:0];
            end else begin
                w_fin[c] = w_shr[c][ACC_W-1:0];
            end
        end
    end
`else
    always_comb begin
        w_fin_valid = r_s2_valid;
        w_fin       = w_acc;
    end
`endif

    // Output register; bubbles load zero data.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_out_acc   <= '0;
        end else if (w_en) begin
            r_out_valid <= w_fin_valid;
            for (int c = 0; c < CH; c++) begin
                r_out_acc[c*ACC_W +: ACC_W] <= w_fin_valid ? w_fin[c] : '0;
            end
        end
    end

endmodule
